// File: rtl/fifo_line_buffer_wr_ctrl.sv
// fifo_line_buffer_wr_ctrl
//
// Write-side controller for the convolution line buffer. Moves one pixel at a
// time from the input AXI-Stream FIFO into one of KERNEL_DIMM BRAM banks (one
// bank per kernel row). A rotating bank pointer marks the newest row, and
// lines_valid counts completed rows, saturating at KERNEL_DIMM.
//
// Optional feature macro: FIFO_BRAM_WR_AUTO_LINE_EN
//   defined   : a write to the last column also advances the bank, exactly as
//               new_line does, in the same cycle as that write.
//   undefined : the column wraps to 0 within the same bank.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   req_pix       one-cycle request: fetch one pixel and store it
//   new_line      one-cycle command: advance to the next bank, column 0
//   pix_ctrl_ack  one-cycle completion pulse for req_pix or new_line
//   fifo_tdata    FIFO output data
//   fifo_tvalid   FIFO has data
//   fifo_tready   pop strobe to the FIFO
//   we_a          one-hot BRAM port-A write enable (bit i = bank i)
//   addr_a        BRAM port-A address (current column)
//   din_a         BRAM port-A write data
//   bank_sel      bank currently being written (newest row)
//   lines_valid   completed rows, saturating at KERNEL_DIMM
//   dbg_state     current FSM state (0 IDLE, 1 FETCH, 2 WRITE, 3 ACK)
//
// Handshake: a FIFO word transfers on a rising edge where fifo_tvalid and
// fifo_tready are both high. fifo_tready is raised only in FETCH and drops on
// the transfer edge, so each req_pix pops exactly one word. The requester side
// is command/ack: req_pix/new_line are honoured only in IDLE, and the next
// command must wait for pix_ctrl_ack.

module fifo_line_buffer_wr_ctrl #(
  parameter int KERNEL_DIMM = 3,
  parameter int LINE_WIDTH  = 16,
  parameter int PIX_W       = 8,
  localparam int ADDR_W     = $clog2(LINE_WIDTH),
  localparam int BANK_W     = $clog2(KERNEL_DIMM),
  localparam int LV_W       = $clog2(KERNEL_DIMM + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_pix,
  input  logic                   new_line,
  output logic                   pix_ctrl_ack,
  input  logic [PIX_W-1:0]       fifo_tdata,
  input  logic                   fifo_tvalid,
  output logic                   fifo_tready,
  output logic [KERNEL_DIMM-1:0] we_a,
  output logic [ADDR_W-1:0]      addr_a,
  output logic [PIX_W-1:0]       din_a,
  output logic [BANK_W-1:0]      bank_sel,
  output logic [LV_W-1:0]        lines_valid,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [KERNEL_DIMM-1:0] WE_ONE    = KERNEL_DIMM'(1);
  localparam logic [BANK_W-1:0]      LAST_BANK = BANK_W'(KERNEL_DIMM - 1);
  localparam logic [LV_W-1:0]        MAX_LINES = LV_W'(KERNEL_DIMM);
  localparam logic [ADDR_W-1:0]      LAST_COL  = ADDR_W'(LINE_WIDTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] col;
  logic [BANK_W-1:0] bank;
  logic [BANK_W-1:0] bank_nxt;
  logic [LV_W-1:0]   lines_nxt;
  logic              col_last;

  // Column and bank registers drive the BRAM address/bank outputs directly,
  // so they hold steady from FETCH through WRITE.
  assign addr_a    = col;
  assign bank_sel  = bank;
  assign dbg_state = state;

  // Explicit wrap: KERNEL_DIMM and LINE_WIDTH need not be powers of two.
  always_comb begin
    bank_nxt  = (bank == LAST_BANK) ? '0 : bank + BANK_W'(1);
    lines_nxt = (lines_valid == MAX_LINES) ? lines_valid : lines_valid + LV_W'(1);
    col_last  = (col == LAST_COL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      col          <= '0;
      bank         <= '0;
      lines_valid  <= '0;
      we_a         <= '0;
      din_a        <= '0;
      fifo_tready  <= 1'b0;
      pix_ctrl_ack <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      we_a         <= '0;
      pix_ctrl_ack <= 1'b0;
      case (state)
        IDLE: begin
          // new_line has priority; a simultaneous req_pix is dropped.
          if (new_line) begin
            col          <= '0;
            bank         <= bank_nxt;
            lines_valid  <= lines_nxt;
            pix_ctrl_ack <= 1'b1;
            state        <= ACK;
          end else if (req_pix) begin
            fifo_tready <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: begin
          // Wait as long as the FIFO is empty; the pop happens on this edge.
          if (fifo_tvalid) begin
            din_a       <= fifo_tdata;
            fifo_tready <= 1'b0;
            we_a        <= WE_ONE << bank;
            state       <= WRITE;
          end
        end
        WRITE: begin
          pix_ctrl_ack <= 1'b1;
          state        <= ACK;
          if (col_last) begin
            col <= '0;
`ifdef FIFO_BRAM_WR_AUTO_LINE_EN
            bank        <= bank_nxt;
            lines_valid <= lines_nxt;
`endif
          end else begin
            col <= col + ADDR_W'(1);
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_line_buffer_wr_ctrl.sv
// Directed testbench for fifo_line_buffer_wr_ctrl at default parameters
// (KERNEL_DIMM=3, LINE_WIDTH=16, PIX_W=8). Latencies are counted as the
// number of rising edges from the edge that samples the command to the edge
// that samples pix_ctrl_ack high.

module tb_fifo_line_buffer_wr_ctrl;

  logic       clk;
  logic       rst;
  logic       req_pix;
  logic       new_line;
  logic       pix_ctrl_ack;
  logic [7:0] fifo_tdata;
  logic       fifo_tvalid;
  logic       fifo_tready;
  logic [2:0] we_a;
  logic [3:0] addr_a;
  logic [7:0] din_a;
  logic [1:0] bank_sel;
  logic [1:0] lines_valid;
  logic [1:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Monitor state
  int         cyc = 0;
  int         pop_cnt = 0;
  int         wr_cnt = 0;
  int         rdy_cnt = 0;
  int         ack_cnt = 0;
  logic [2:0] wr_we;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  logic [7:0] exp_q[$];

  fifo_line_buffer_wr_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_pix      (req_pix),
    .new_line     (new_line),
    .pix_ctrl_ack (pix_ctrl_ack),
    .fifo_tdata   (fifo_tdata),
    .fifo_tvalid  (fifo_tvalid),
    .fifo_tready  (fifo_tready),
    .we_a         (we_a),
    .addr_a       (addr_a),
    .din_a        (din_a),
    .bank_sel     (bank_sel),
    .lines_valid  (lines_valid),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  // ---------------- monitors ----------------
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_tready && fifo_tvalid) pop_cnt <= pop_cnt + 1;
  end

  always @(negedge clk) begin
    if (we_a != 3'b000) begin
      wr_cnt  <= wr_cnt + 1;
      wr_we   <= we_a;
      wr_addr <= addr_a;
      wr_data <= din_a;
    end
    if (fifo_tready)  rdy_cnt <= rdy_cnt + 1;
    if (pix_ctrl_ack) ack_cnt <= ack_cnt + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    rst = 1'b1;
    req_pix = 1'b0;
    new_line = 1'b0;
    fifo_tvalid = 1'b0;
    fifo_tdata = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One req_pix; FIFO empty for 'stall' edges after the request edge.
  task automatic do_req(input logic [7:0] data, input int stall, output int lat);
    int req_cyc;
    lat = -1;
    @(posedge clk);
    #1;
    req_pix = 1'b1;
    fifo_tdata = data;
    fifo_tvalid = (stall == 0);
    @(posedge clk);
    req_cyc = cyc + 1;
    #1;
    req_pix = 1'b0;
    if (stall > 0) begin
      repeat (stall) @(posedge clk);
      #1;
      fifo_tvalid = 1'b1;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pix_ctrl_ack) begin
        lat = cyc + 1 - req_cyc;
        break;
      end
    end
    fifo_tvalid = 1'b0;
    #1;
  endtask

  // One new_line, optionally with a simultaneous req_pix.
  task automatic do_cmd(input logic with_req, output int lat);
    int req_cyc;
    lat = -1;
    @(posedge clk);
    #1;
    new_line = 1'b1;
    req_pix = with_req;
    fifo_tvalid = with_req;
    fifo_tdata = 8'hEE;
    @(posedge clk);
    req_cyc = cyc + 1;
    #1;
    new_line = 1'b0;
    req_pix = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pix_ctrl_ack) begin
        lat = cyc + 1 - req_cyc;
        break;
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_vec++; if (we_a !== 3'b000) begin n_err++; $display("FAIL reset_we_a got %b exp 000", we_a); end
    n_vec++; if (addr_a !== 4'h0) begin n_err++; $display("FAIL reset_addr_a got %0h exp 0", addr_a); end
    n_vec++; if (din_a !== 8'h00) begin n_err++; $display("FAIL reset_din_a got %0h exp 0", din_a); end
    n_vec++; if (fifo_tready !== 1'b0) begin n_err++; $display("FAIL reset_tready got %b exp 0", fifo_tready); end
    n_vec++; if (pix_ctrl_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b exp 0", pix_ctrl_ack); end
    n_vec++; if (bank_sel !== 2'd0) begin n_err++; $display("FAIL reset_bank_sel got %0d exp 0", bank_sel); end
    n_vec++; if (lines_valid !== 2'd0) begin n_err++; $display("FAIL reset_lines_valid got %0d exp 0", lines_valid); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    apply_reset();
  endtask

  // 16 back-to-back pixels fill bank 0, one pop and one write each.
  task automatic test_fill();
    int lat, p0, w0, n0;
    logic [7:0] exp_d;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 16; i++) begin
      exp_d = exp_q.pop_front();
      p0 = pop_cnt; w0 = wr_cnt; n0 = rdy_cnt;
      do_req(exp_d, 0, lat);
      n_vec++; if (lat !== 3) begin n_err++; $display("FAIL fill_latency[%0d] got %0d exp 3", i, lat); end
      n_vec++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL fill_writes[%0d] got %0d exp 1", i, wr_cnt - w0); end
      n_vec++; if (pop_cnt - p0 !== 1) begin n_err++; $display("FAIL fill_pops[%0d] got %0d exp 1", i, pop_cnt - p0); end
      n_vec++; if (rdy_cnt - n0 !== 1) begin n_err++; $display("FAIL fill_tready_cycles[%0d] got %0d exp 1", i, rdy_cnt - n0); end
      n_vec++; if (wr_we !== 3'b001) begin n_err++; $display("FAIL fill_we[%0d] got %b exp 001", i, wr_we); end
      n_vec++; if (wr_addr !== 4'(i)) begin n_err++; $display("FAIL fill_addr[%0d] got %0d exp %0d", i, wr_addr, i); end
      n_vec++; if (wr_data !== exp_d) begin n_err++; $display("FAIL fill_data[%0d] got %0h exp %0h", i, wr_data, exp_d); end
    end
  endtask

  // 17th write: wraps to column 0 of bank 0, or of bank 1 with auto-line.
  task automatic test_wrap();
    int lat;
    logic [1:0] exp_bank, exp_lv;
    logic [2:0] exp_we;
`ifdef FIFO_BRAM_WR_AUTO_LINE_EN
    exp_bank = 2'd1; exp_lv = 2'd1; exp_we = 3'b010;
`else
    exp_bank = 2'd0; exp_lv = 2'd0; exp_we = 3'b001;
`endif
    n_vec++; if (bank_sel !== exp_bank) begin n_err++; $display("FAIL wrap_bank_after16 got %0d exp %0d", bank_sel, exp_bank); end
    n_vec++; if (lines_valid !== exp_lv) begin n_err++; $display("FAIL wrap_lines_after16 got %0d exp %0d", lines_valid, exp_lv); end
    do_req(8'h10, 0, lat);
    n_vec++; if (wr_we !== exp_we) begin n_err++; $display("FAIL wrap_we got %b exp %b", wr_we, exp_we); end
    n_vec++; if (wr_addr !== 4'd0) begin n_err++; $display("FAIL wrap_addr got %0d exp 0", wr_addr); end
    n_vec++; if (wr_data !== 8'h10) begin n_err++; $display("FAIL wrap_data got %0h exp 10", wr_data); end
    n_vec++; if (lines_valid !== exp_lv) begin n_err++; $display("FAIL wrap_lines got %0d exp %0d", lines_valid, exp_lv); end
  endtask

  // Empty FIFO for 5 cycles: tready held 6 cycles, one pop, ack at req+8.
  task automatic test_stall();
    int lat, p0, w0, n0;
    p0 = pop_cnt; w0 = wr_cnt; n0 = rdy_cnt;
    do_req(8'hA5, 5, lat);
    n_vec++; if (lat !== 8) begin n_err++; $display("FAIL stall_latency got %0d exp 8", lat); end
    n_vec++; if (rdy_cnt - n0 !== 6) begin n_err++; $display("FAIL stall_tready_cycles got %0d exp 6", rdy_cnt - n0); end
    n_vec++; if (pop_cnt - p0 !== 1) begin n_err++; $display("FAIL stall_pops got %0d exp 1", pop_cnt - p0); end
    n_vec++; if (wr_cnt - w0 !== 1) begin n_err++; $display("FAIL stall_writes got %0d exp 1", wr_cnt - w0); end
    n_vec++; if (wr_data !== 8'hA5) begin n_err++; $display("FAIL stall_data got %0h exp a5", wr_data); end
    n_vec++; if (wr_addr !== 4'd1) begin n_err++; $display("FAIL stall_addr got %0d exp 1", wr_addr); end
  endtask

  // Reset asserted during WRITE kills the write strobe and the ack.
  task automatic test_reset_in_write();
    int a0, w0, p0, lat;
    @(posedge clk);
    #1;
    req_pix = 1'b1;
    fifo_tdata = 8'h77;
    fifo_tvalid = 1'b1;
    @(posedge clk);
    #1;
    req_pix = 1'b0;
    @(posedge clk);
    #1;
    fifo_tvalid = 1'b0;
    @(negedge clk);
    n_vec++; if (dbg_state !== 2'd2) begin n_err++; $display("FAIL rstw_in_write got %0d exp 2", dbg_state); end
    #1;
    rst = 1'b1;
    #1;
    n_vec++; if (we_a !== 3'b000) begin n_err++; $display("FAIL rstw_we_drop got %b exp 000", we_a); end
    n_vec++; if (pix_ctrl_ack !== 1'b0) begin n_err++; $display("FAIL rstw_ack got %b exp 0", pix_ctrl_ack); end
    @(negedge clk);
    #1;
    a0 = ack_cnt; w0 = wr_cnt; p0 = pop_cnt;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    n_vec++; if (ack_cnt - a0 !== 0) begin n_err++; $display("FAIL rstw_no_ack got %0d exp 0", ack_cnt - a0); end
    n_vec++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL rstw_no_write got %0d exp 0", wr_cnt - w0); end
    do_req(8'h3C, 0, lat);
    n_vec++; if (pop_cnt - p0 !== 1) begin n_err++; $display("FAIL rstw_pops got %0d exp 1", pop_cnt - p0); end
    n_vec++; if (wr_we !== 3'b001) begin n_err++; $display("FAIL rstw_next_we got %b exp 001", wr_we); end
    n_vec++; if (wr_addr !== 4'd0) begin n_err++; $display("FAIL rstw_next_addr got %0d exp 0", wr_addr); end
    n_vec++; if (wr_data !== 8'h3C) begin n_err++; $display("FAIL rstw_next_data got %0h exp 3c", wr_data); end
  endtask

  // Four new_line commands from reset: bank rotates, lines_valid saturates.
  task automatic test_new_line();
    logic [1:0] exp_bank[4];
    logic [1:0] exp_lv[4];
    int lat;
    exp_bank = '{2'd1, 2'd2, 2'd0, 2'd1};
    exp_lv   = '{2'd1, 2'd2, 2'd3, 2'd3};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_cmd(1'b0, lat);
      n_vec++; if (lat !== 1) begin n_err++; $display("FAIL nl_latency[%0d] got %0d exp 1", i, lat); end
      n_vec++; if (bank_sel !== exp_bank[i]) begin n_err++; $display("FAIL nl_bank[%0d] got %0d exp %0d", i, bank_sel, exp_bank[i]); end
      n_vec++; if (lines_valid !== exp_lv[i]) begin n_err++; $display("FAIL nl_lines[%0d] got %0d exp %0d", i, lines_valid, exp_lv[i]); end
    end
    // Column reset by new_line: next pixel lands in bank 1, address 0.
    do_req(8'h5A, 0, lat);
    n_vec++; if (wr_we !== 3'b010) begin n_err++; $display("FAIL nl_pix_we got %b exp 010", wr_we); end
    n_vec++; if (wr_addr !== 4'd0) begin n_err++; $display("FAIL nl_pix_addr got %0d exp 0", wr_addr); end
  endtask

  // req_pix and new_line together: bank advance only.
  task automatic test_collision();
    int lat, a0, w0, p0;
    a0 = ack_cnt; w0 = wr_cnt; p0 = pop_cnt;
    do_cmd(1'b1, lat);
    fifo_tvalid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL coll_latency got %0d exp 1", lat); end
    n_vec++; if (bank_sel !== 2'd2) begin n_err++; $display("FAIL coll_bank got %0d exp 2", bank_sel); end
    n_vec++; if (lines_valid !== 2'd3) begin n_err++; $display("FAIL coll_lines got %0d exp 3", lines_valid); end
    n_vec++; if (ack_cnt - a0 !== 1) begin n_err++; $display("FAIL coll_acks got %0d exp 1", ack_cnt - a0); end
    n_vec++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL coll_writes got %0d exp 0", wr_cnt - w0); end
    n_vec++; if (pop_cnt - p0 !== 0) begin n_err++; $display("FAIL coll_pops got %0d exp 0", pop_cnt - p0); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL coll_state got %0d exp 0", dbg_state); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    req_pix = 1'b0;
    new_line = 1'b0;
    fifo_tvalid = 1'b0;
    fifo_tdata = 8'h00;
    test_reset();
    test_fill();
    test_wrap();
    test_stall();
    test_reset_in_write();
    test_new_line();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_line_buffer_wr_ctrl.md
# fifo_line_buffer_wr_ctrl

Parametrised write-side controller that moves pixels from the input AXI-Stream FIFO into the KERNEL_DIMM line-buffer BRAM banks feeding the convolution window. It serves single-pixel requests and line-advance commands from the input matrix control unit. It generalises the fixed 3-row, 4-bit-address control unit in three ways:
- configurable kernel size, line length and pixel width;
- one-hot bank selection with a rotating newest-row pointer;
- a row-fill status count.

## Interface
- KERNEL_DIMM, 3, number of line-buffer banks (rows of the kernel window); ≥2
- LINE_WIDTH, 16, pixels per line; depth of each bank; ≥2
- PIX_W, 8, pixel width in bits
- ADDR_W (localparam), $clog2(LINE_WIDTH), BRAM address width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_pix  in  1  one-cycle request: fetch and store one pixel
- new_line  in  1  one-cycle command: advance to next bank, column 0
- pix_ctrl_ack  out  1  one-cycle completion pulse for req_pix or new_line
- fifo_tdata  in  PIX_W  FIFO output data
- fifo_tvalid  in  1  FIFO has data
- fifo_tready  out  1  pop strobe to FIFO
- we_a  out  KERNEL_DIMM  one-hot BRAM port-A write enable, bit i = bank i
- addr_a  out  ADDR_W  BRAM port-A address (current column)
- din_a  out  PIX_W  BRAM port-A write data
- bank_sel  out  $clog2(KERNEL_DIMM)  bank currently being written (newest row)
- lines_valid  out  $clog2(KERNEL_DIMM+1)  completed rows, saturating at KERNEL_DIMM

## Operation
- FSM states: IDLE, FETCH, WRITE, ACK. All outputs are registered or Moore-decoded from state; no combinational input-to-output paths.
- IDLE:
  - new_line=1: col←0, bank←(bank+1) mod KERNEL_DIMM, lines_valid←min(lines_valid+1, KERNEL_DIMM), go to ACK.
  - else req_pix=1: go to FETCH.
  - new_line wins over a simultaneous req_pix; that req_pix is dropped.
- FETCH: fifo_tready=1. On fifo_tvalid=1, capture fifo_tdata into din_a and go to WRITE. Otherwise wait indefinitely; no timeout.
- WRITE: we_a=1<<bank for exactly one cycle with addr_a=col and din_a stable, then go to ACK.
  - col increments after the write.
  - At col==LINE_WIDTH-1 the column wraps per Configuration.
- ACK: pix_ctrl_ack=1 for one cycle, then IDLE.
- req_pix/new_line outside IDLE are ignored. The requester must wait for pix_ctrl_ack before issuing the next command.
- Bank pointer wraps KERNEL_DIMM-1 → 0. lines_valid never decrements except on reset.

## Timing
- Reset values (async assert, sync-safe deassert):
  - state: IDLE; col, bank, lines_valid: 0.
  - we_a, addr_a, din_a: 0; fifo_tready, pix_ctrl_ack: 0.
- req_pix sampled at edge N:
  - fifo_tready high from N+1.
  - With fifo_tvalid=1 at N+1, data popped at edge N+1, we_a high in N+2, pix_ctrl_ack high in N+3.
  - Minimum latency: 3 cycles, 4 cycles request-to-request.
- Each empty-FIFO cycle in FETCH adds one cycle. Exactly one pop per req_pix.
- new_line sampled at N: bank_sel and lines_valid update at N+1, pix_ctrl_ack high in N+1.
- addr_a and bank_sel are stable from FETCH through WRITE. The col increment is visible in ACK.
- Reset during FETCH or WRITE:
  - No write or pop completes after the reset assertion edge.
  - No ack is issued.
  - The FIFO word is lost if the pop edge has not yet occurred.

## Configuration
- Macro: FIFO_BRAM_WR_AUTO_LINE_EN.
- Defined: a write at col==LINE_WIDTH-1 wraps col to 0 and also advances bank and lines_valid exactly as new_line does, in the same cycle as the write. A later explicit new_line advances again.
- Undefined: col wraps to 0 within the same bank. Only new_line changes bank and lines_valid.

## Test plan
- Reset, then 16 req_pix with fifo_tvalid=1 and data 0x00..0x0F (defaults) → bank 0 addr 0..15 receive 0x00..0x0F. Each ack arrives 3 cycles after its req. we_a=3'b001 only.
- req_pix with fifo_tvalid=0 for 5 cycles, then 1 → fifo_tready held 5 extra cycles, single pop, ack at req+8.
- new_line ×4 from reset → bank_sel 1,2,0,1; lines_valid 1,2,3,3; each ack 1 cycle after the command.
- req_pix and new_line in the same cycle → bank advance only, no pop, no write, one ack.
- With FIFO_BRAM_WR_AUTO_LINE_EN: 17 writes → write 16 in bank 0 addr 15, write 17 in bank 1 addr 0, lines_valid=1. Without the macro: write 17 goes to bank 0 addr 0, lines_valid=0.
- rst asserted in the WRITE cycle → we_a drops immediately, no ack. After release, the next req_pix writes bank 0 addr 0.
